// File: rtl/alu_uart_interface.sv
// Sequencer between UART rx/tx and ALU: collects A, B, operator bytes, then transmits the result.
// Optional inter-byte timeout enabled by defining ALU_IF_TIMEOUT_EN.
module alu_uart_interface #(
    parameter int N_BITS         = 8,
    parameter int N_BITS_OP      = 6,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [N_BITS-1:0]    i_rx_data,
    input  logic                 i_rx_done,
    input  logic                 i_tx_done,
    input  logic [N_BITS-1:0]    i_alu_result,
    output logic [N_BITS-1:0]    o_data1,
    output logic [N_BITS-1:0]    o_data2,
    output logic [N_BITS_OP-1:0] o_operator,
    output logic [N_BITS-1:0]    o_tx_data,
    output logic                 o_tx_start,
    output logic                 o_timeout
);

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        SEND    = 3'd3,
        WAIT_TX = 3'd4
    } state_t;

    state_t state;
    logic   expire;

    // upper operator-byte bits are intentionally dropped
    logic unused_rx_hi;
    assign unused_rx_hi = ^i_rx_data[N_BITS-1:N_BITS_OP];

`ifdef ALU_IF_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;
    logic          waiting;

    assign waiting = (state == WAIT_B) || (state == WAIT_OP);
    assign expire  = (cnt == CNT_MAX);

    // counter runs only while a frame is partially received; any byte restarts it
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt       <= '0;
            o_timeout <= 1'b0;
        end else begin
            o_timeout <= 1'b0;
            if (waiting && !i_rx_done) begin
                if (expire) begin
                    cnt       <= '0;
                    o_timeout <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign expire    = 1'b0;
    assign o_timeout = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state      <= WAIT_A;
            o_data1    <= '0;
            o_data2    <= '0;
            o_operator <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
        end else begin
            o_tx_start <= 1'b0;
            case (state)
                WAIT_A: begin
                    if (i_rx_done) begin
                        o_data1 <= i_rx_data;
                        state   <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (i_rx_done) begin
                        o_data2 <= i_rx_data;
                        state   <= WAIT_OP;
                    end else if (expire) begin
                        state <= WAIT_A;
                    end
                end
                WAIT_OP: begin
                    if (i_rx_done) begin
                        o_operator <= i_rx_data[N_BITS_OP-1:0];
                        state      <= SEND;
                    end else if (expire) begin
                        state <= WAIT_A;
                    end
                end
                // ALU inputs settled one cycle ago; latch its result for the transmitter
                SEND: begin
                    o_tx_data  <= i_alu_result;
                    o_tx_start <= 1'b1;
                    state      <= WAIT_TX;
                end
                WAIT_TX: begin
                    if (i_tx_done) state <= WAIT_A;
                end
                default: state <= WAIT_A;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_uart_interface.sv
// Directed bench for alu_uart_interface with a small behavioural ALU on the outputs.
module tb_alu_uart_interface;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       tx_done;
    logic [7:0] alu_result;
    logic [7:0] data1, data2, tx_data;
    logic [5:0] operator;
    logic       tx_start, timeout;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    alu_uart_interface #(.N_BITS(8), .N_BITS_OP(6), .TIMEOUT_CYCLES(16)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_rx_data    (rx_data),
        .i_rx_done    (rx_done),
        .i_tx_done    (tx_done),
        .i_alu_result (alu_result),
        .o_data1      (data1),
        .o_data2      (data2),
        .o_operator   (operator),
        .o_tx_data    (tx_data),
        .o_tx_start   (tx_start),
        .o_timeout    (timeout)
    );

    // external ALU: ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, anything else 0
    always_comb begin
        case (operator)
            6'h20:   alu_result = data1 + data2;
            6'h22:   alu_result = data1 - data2;
            6'h24:   alu_result = data1 & data2;
            6'h25:   alu_result = data1 | data2;
            default: alu_result = 8'h00;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic pulse_tx_done();
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    // operator byte sampled at edge k; SEND during k..k+1; tx_start seen after k+1 only
    task automatic frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] op, input logic [5:0] exp_op,
                         input logic [7:0] exp_res, input bit finish_tx);
        send_byte(a);
        send_byte(b);
        send_byte(op);
        chk({tag, " data1"}, data1, a);
        chk({tag, " data2"}, data2, b);
        chk({tag, " operator"}, operator, exp_op);
        chk({tag, " start early"}, tx_start, 0);
        @(negedge clk);
        chk({tag, " start"}, tx_start, 1);
        chk({tag, " tx_data"}, tx_data, exp_res);
        @(negedge clk);
        chk({tag, " start width"}, tx_start, 0);
        if (finish_tx) pulse_tx_done();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " data1"}, data1, 0);
        chk({tag, " data2"}, data2, 0);
        chk({tag, " operator"}, operator, 0);
        chk({tag, " tx_data"}, tx_data, 0);
        chk({tag, " tx_start"}, tx_start, 0);
        chk({tag, " timeout"}, timeout, 0);
    endtask

    initial begin
        int pulses;
        rst = 1'b1; rx_data = 8'h00; rx_done = 1'b0; tx_done = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        // stray tx_done in WAIT_A must be harmless
        pulse_tx_done();

        frame("add", 8'h05, 8'h03, 8'h20, 6'b100000, 8'h08, 1);
        frame("sub", 8'h03, 8'h05, 8'h22, 6'b100010, 8'hFE, 1);
        frame("and", 8'h0F, 8'h33, 8'hE4, 6'b100100, 8'h03, 0);

        // byte during WAIT_TX dropped, no second start
        send_byte(8'h11);
        chk("wtx data1", data1, 8'h0F);
        pulses = 0;
        repeat (4) begin
            @(negedge clk);
            if (tx_start) pulses++;
        end
        chk("wtx no restart", pulses, 0);
        chk("wtx tx_data held", tx_data, 8'h03);

        // simultaneous rx_done + tx_done: leave WAIT_TX, drop the byte
        @(negedge clk);
        rx_data = 8'h44; rx_done = 1'b1; tx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0; tx_done = 1'b0;
        chk("simul data1", data1, 8'h0F);

        frame("add2", 8'h01, 8'h01, 8'h20, 6'b100000, 8'h02, 1);
        frame("inval", 8'h7F, 8'h01, 8'h3F, 6'b111111, 8'h00, 1);

        // reset mid-frame
        send_byte(8'h05);
        send_byte(8'h03);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (4) begin
            @(negedge clk);
            if (tx_start) pulses++;
        end
        chk("midrst no start", pulses, 0);
        frame("postrst", 8'h02, 8'h02, 8'h20, 6'b100000, 8'h04, 1);

        // inter-byte idle
        send_byte(8'h05);
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (timeout) pulses++;
        end
`ifdef ALU_IF_TIMEOUT_EN
        chk("to pulses", pulses, 1);
        chk("to data1 kept", data1, 8'h05);
        frame("to next", 8'h09, 8'h01, 8'h20, 6'b100000, 8'h0A, 1);
`else
        chk("no timeout", pulses, 0);
        send_byte(8'h03);
        send_byte(8'h20);
        chk("idle data1", data1, 8'h05);
        @(negedge clk);
        chk("idle start", tx_start, 1);
        chk("idle tx_data", tx_data, 8'h08);
        pulse_tx_done();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
